// File: rtl/hazard_scheduler.sv
// Dual-issue hazard scheduler: per-register readiness scoreboard plus a non-pipelined MUL busy counter.
// Define HAZARD_FWD_EN to let a producer one cycle from ready forward into its consumer.
module hazard_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       i0_valid,
  input  logic       i1_valid,
  input  logic [1:0] i0_unit,
  input  logic [1:0] i1_unit,
  input  logic       i0_wr,
  input  logic       i1_wr,
  input  logic [4:0] i0_rd,
  input  logic [4:0] i0_rs1,
  input  logic [4:0] i0_rs2,
  input  logic [4:0] i1_rd,
  input  logic [4:0] i1_rs1,
  input  logic [4:0] i1_rs2,
  output logic       is_struct_hazard,
  output logic [1:0] is_raw_hazard,
  output logic       issue0,
  output logic       issue1,
  output logic       hold
);

  typedef enum logic [1:0] {
    UNIT_NONE = 2'b00,
    UNIT_ALU  = 2'b01,
    UNIT_MUL  = 2'b10,
    UNIT_LDST = 2'b11
  } unit_e;

  logic [1:0] sb     [32];
  logic [1:0] sb_nxt [32];
  logic [1:0] mul_busy;

  logic en, pair, intra, raw_nf, raw_f, wr0, wr1, mul_start;

  function automatic logic blocked(input logic [1:0] cnt);
`ifdef HAZARD_FWD_EN
    return cnt > 2'd1;
`else
    return cnt != 2'd0;
`endif
  endfunction

  function automatic logic [1:0] latency(input logic [1:0] unit);
    case (unit)
      UNIT_ALU:  return 2'd1;
      UNIT_LDST: return 2'd2;
      UNIT_MUL:  return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  always_comb begin
    en    = active & ~reset;
    hold  = en & i0_valid & (blocked(sb[i0_rs1]) | blocked(sb[i0_rs2]) |
                             ((i0_unit == UNIT_MUL) && (mul_busy != '0)));
    issue0 = en & i0_valid & ~hold;
    pair   = issue0 & i1_valid;
    intra  = i0_wr && (i0_rd != '0) && ((i1_rs1 == i0_rd) || (i1_rs2 == i0_rd));

    is_struct_hazard = pair & (((i0_unit == i1_unit) && (i0_unit != UNIT_NONE)) |
                               ((i1_unit == UNIT_MUL) && (mul_busy != '0)));
    // Without forwarding an intra-pair dependency is as hard as a pending producer.
`ifdef HAZARD_FWD_EN
    raw_nf = pair & ~is_struct_hazard & (blocked(sb[i1_rs1]) | blocked(sb[i1_rs2]));
    raw_f  = pair & ~is_struct_hazard & ~raw_nf & intra;
`else
    raw_nf = pair & ~is_struct_hazard & (blocked(sb[i1_rs1]) | blocked(sb[i1_rs2]) | intra);
    raw_f  = 1'b0;
`endif
    is_raw_hazard = {raw_nf, raw_f};
    issue1 = pair & ~is_struct_hazard & ~raw_nf & ~raw_f;

    wr0       = issue0 & i0_wr & (i0_unit != UNIT_NONE) & (i0_rd != '0);
    wr1       = issue1 & i1_wr & (i1_unit != UNIT_NONE) & (i1_rd != '0);
    mul_start = (issue0 & (i0_unit == UNIT_MUL)) | (issue1 & (i1_unit == UNIT_MUL));
  end

  // Slot 1 is applied last so it wins a same-rd collision.
  always_comb begin
    for (int unsigned r = 0; r < 32; r++)
      sb_nxt[r] = (sb[r] != '0) ? sb[r] - 2'd1 : '0;
    if (wr0) sb_nxt[i0_rd] = latency(i0_unit);
    if (wr1) sb_nxt[i1_rd] = latency(i1_unit);
    sb_nxt[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb       <= '{default: '0};
      mul_busy <= '0;
    end else begin
      sb <= sb_nxt;
      if (mul_start)             mul_busy <= 2'd3;
      else if (mul_busy != '0)   mul_busy <= mul_busy - 2'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized + directed bench for hazard_scheduler; expectations come from a cycle-count model
// queued at stimulus time and checked by an independent monitor.
module tb_hazard_scheduler;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [1:0] u;
    logic       wr;
    logic [4:0] rd, rs1, rs2;
  } slot_t;

  typedef struct packed {
    logic       s;
    logic [1:0] raw;
    logic       i0, i1, h;
  } exp_t;

  logic clk = 0, reset = 1, active = 0;
  slot_t d0, d1;
  logic       is_struct_hazard, issue0, issue1, hold;
  logic [1:0] is_raw_hazard;

  int n_checks = 0, n_fail = 0;
  exp_t q[$];
  int msb[32];      // cycles until each register's value is forwardable
  int mbusy;        // cycles until the multiplier accepts again
  logic last_hold;

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk(clk), .reset(reset), .active(active),
    .i0_valid(d0.v), .i1_valid(d1.v), .i0_unit(d0.u), .i1_unit(d1.u),
    .i0_wr(d0.wr), .i1_wr(d1.wr),
    .i0_rd(d0.rd), .i0_rs1(d0.rs1), .i0_rs2(d0.rs2),
    .i1_rd(d1.rd), .i1_rs1(d1.rs1), .i1_rs2(d1.rs2),
    .is_struct_hazard(is_struct_hazard), .is_raw_hazard(is_raw_hazard),
    .issue0(issue0), .issue1(issue1), .hold(hold)
  );

  function automatic slot_t mk(int v, int u, int wr, int rd, int rs1, int rs2);
    slot_t s;
    s.v = v[0]; s.u = u[1:0]; s.wr = wr[0];
    s.rd = rd[4:0]; s.rs1 = rs1[4:0]; s.rs2 = rs2[4:0];
    return s;
  endfunction

  function automatic int lat(logic [1:0] u);
    return (u == 2'd1) ? 1 : (u == 2'd3) ? 2 : (u == 2'd2) ? 3 : 0;
  endfunction

  function automatic bit waits(int r);
    return FWD ? (msb[r] > 1) : (msb[r] > 0);
  endfunction

  task automatic chk(string nm, logic [1:0] got, logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("struct", {1'b0, is_struct_hazard}, {1'b0, e.s});
      chk("raw",    is_raw_hazard,            e.raw);
      chk("issue0", {1'b0, issue0},           {1'b0, e.i0});
      chk("issue1", {1'b0, issue1},           {1'b0, e.i1});
      chk("hold",   {1'b0, hold},             {1'b0, e.h});
    end
  end

  // One cycle: drive, predict, let the edge happen, advance the model.
  task automatic step(input logic a, input slot_t s0, input slot_t s1);
    exp_t e;
    bit pair, intra;
    e = '0;
    active = a; d0 = s0; d1 = s1;
    if (reset) begin
      foreach (msb[r]) msb[r] = 0;
      mbusy = 0;
    end else if (a && s0.v) begin
      e.h = waits(s0.rs1) || waits(s0.rs2) || (s0.u == 2'd2 && mbusy > 0);
      e.i0 = !e.h;
      pair = e.i0 && s1.v;
      intra = s0.wr && s0.rd != 0 && (s1.rs1 == s0.rd || s1.rs2 == s0.rd);
      if (pair) begin
        if ((s0.u == s1.u && s0.u != 0) || (s1.u == 2'd2 && mbusy > 0)) e.s = 1;
        else if (waits(s1.rs1) || waits(s1.rs2) || (intra && !FWD)) e.raw = 2'b10;
        else if (intra) e.raw = 2'b01;
        else e.i1 = 1;
      end
    end
    q.push_back(e);
    #1 last_hold = hold;
    @(posedge clk);
    if (!reset) begin
      foreach (msb[r]) if (msb[r] > 0) msb[r]--;
      if (mbusy > 0) mbusy--;
      if (e.i0 && s0.wr && s0.u != 0 && s0.rd != 0) msb[s0.rd] = lat(s0.u);
      if (e.i1 && s1.wr && s1.u != 0 && s1.rd != 0) msb[s1.rd] = lat(s1.u);
      if ((e.i0 && s0.u == 2'd2) || (e.i1 && s1.u == 2'd2)) mbusy = 3;
    end
    #1;
  endtask

  slot_t none;
  int holds;

  initial begin
    none = mk(0, 0, 0, 0, 0, 0);
    d0 = none; d1 = none;
    foreach (msb[r]) msb[r] = 0;
    mbusy = 0;
    @(posedge clk); #1;
    // Outputs forced low while reset is held, even with a valid pair presented.
    step(1, mk(1, 1, 1, 3, 0, 0), mk(1, 2, 1, 4, 0, 0));
    reset = 0;

    // ALU/ALU pair: structural hazard wins over the intra-pair dependency.
    step(1, mk(1, 1, 1, 3, 0, 0), mk(1, 1, 1, 4, 3, 0));
    // Intra-pair dependency ALU -> LDST.
    step(1, mk(1, 1, 1, 5, 0, 0), mk(1, 3, 1, 6, 0, 5));
    repeat (4) step(1, none, none);

    // MUL rd=7 then an ALU consumer: hold count depends on forwarding.
    step(1, mk(1, 2, 1, 7, 0, 0), none);
    holds = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, mk(1, 1, 0, 0, 7, 0), none);
      if (last_hold) holds++;
      else break;
    end
    chk("mul_hold_cycles", holds[1:0], FWD ? 2'd2 : 2'd3);
    repeat (4) step(1, none, none);

    // Busy multiplier: second MUL in slot 1 is structural until it frees, then slot 0 MUL holds.
    step(1, mk(1, 2, 1, 8, 0, 0), none);
    repeat (4) step(1, mk(1, 1, 1, 10, 0, 0), mk(1, 2, 1, 11, 12, 0));
    repeat (4) step(1, mk(1, 2, 1, 12, 0, 0), none);
    repeat (4) step(1, none, none);

    // Same-rd pair, then async reset mid-countdown; r9 must be ready afterwards.
    step(1, mk(1, 1, 1, 9, 0, 0), mk(1, 3, 1, 9, 0, 0));
    #2 reset = 1;
    step(1, mk(1, 1, 0, 0, 9, 0), none);
    reset = 0;
    step(1, mk(1, 1, 0, 0, 9, 9), mk(1, 3, 0, 0, 9, 0));

    // Writes to r0 are discarded.
    step(1, mk(1, 2, 1, 0, 0, 0), none);
    step(1, mk(1, 1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0));
    step(0, mk(1, 1, 1, 2, 0, 0), mk(1, 3, 1, 3, 2, 0));
    repeat (4) step(1, none, none);

    for (int i = 0; i < 600; i++) begin
      slot_t a, b;
      a = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      b = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step(($urandom_range(0, 9) != 0), a, b);
    end

    @(negedge clk);
    chk("queue_drained", q.size() == 0 ? 2'd0 : 2'd1, 2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
